mac_acc: RTL and testbench

MAC_ACC -- requirements
Module: mac_acc

---
 rtl/mac_pkg.sv | 14 +
 rtl/sat_add.sv | 28 ++
 rtl/mac_acc.sv | 88 ++++++++
 tb/tb_mac_acc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the mac_acc dot-product accumulator
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_P_WIDTH   = 16;
  localparam int DEF_ACC_WIDTH = 24;
  localparam int DEF_N_TERMS   = 16;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed accumulator adder; clamps on overflow when MAC_ACC_SAT_EN is defined, wraps otherwise
module sat_add import mac_pkg::*; #(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] i_a,
  input  logic signed [ACC_WIDTH-1:0] i_b,
  output logic signed [ACC_WIDTH-1:0] o_sum,
  output logic                        o_ovf
);

  logic signed [ACC_WIDTH-1:0] w_raw;
  assign w_raw = i_a + i_b;

`ifdef MAC_ACC_SAT_EN
  // Overflow only when both operands share a sign the raw sum does not.
  logic w_ovf;
  assign w_ovf = (i_a[ACC_WIDTH-1] == i_b[ACC_WIDTH-1]) &&
                 (w_raw[ACC_WIDTH-1] != i_a[ACC_WIDTH-1]);
  assign o_ovf = w_ovf;
  assign o_sum = !w_ovf ? w_raw :
                 i_a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign o_ovf = 1'b0;
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/mac_acc.sv
// rtl/mac_acc.sv - accumulates N_TERMS signed products into one held result (saturation: MAC_ACC_SAT_EN)
module mac_acc import mac_pkg::*; #(
  parameter int P_WIDTH   = DEF_P_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int N_TERMS   = DEF_N_TERMS
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [P_WIDTH-1:0]   in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        sat
);

  localparam int CW = $clog2(N_TERMS + 1);

  state_t                      r_state;
  state_t                      w_next;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic        [CW-1:0]        r_count;
  logic                        r_sat;

  logic                        w_accept;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_a;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_ovf;
  logic        [CW-1:0]        w_cnt_next;

  assign w_accept   = in_valid && in_ready;
  assign w_ext      = ACC_WIDTH'(in_data);
  assign w_a        = (r_state == IDLE) ? '0 : r_acc;
  assign w_cnt_next = (r_state == IDLE) ? CW'(1) : r_count + CW'(1);

  sat_add #(.ACC_WIDTH(ACC_WIDTH)) u_sat_add (
    .i_a   (w_a),
    .i_b   (w_ext),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc   <= w_sum;
        r_count <= w_cnt_next;
        r_sat   <= ((r_state == IDLE) ? 1'b0 : r_sat) | w_ovf;
      end else if (r_state == HOLD && out_ready) begin
        r_acc   <= '0;
        r_count <= '0;
        r_sat   <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ACCUM: if (w_accept && w_cnt_next == CW'(N_TERMS)) w_next = HOLD;
                   else if (w_accept) w_next = ACCUM;
      HOLD:        if (out_ready) w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state != HOLD);
    out_valid = (r_state == HOLD);
    out_data  = r_acc;
    sat       = r_sat;
  end

endmodule

// File: tb/tb_mac_acc.sv
// tb/tb_mac_acc.sv - directed bench for mac_acc, two instances (24-bit and 16-bit accumulators, 4 terms)
module tb_mac_acc;

  localparam int NT = 4;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               clr;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;

  logic               rdy0, vld0, sat0;
  logic signed [23:0] od0;
  logic               rdy1, vld1, sat1;
  logic signed [15:0] od1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mac_acc #(.P_WIDTH(16), .ACC_WIDTH(24), .N_TERMS(NT)) dut (
    .clk(clk), .n_rst(n_rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .out_valid(vld0), .out_ready(out_ready), .out_data(od0), .sat(sat0)
  );

  mac_acc #(.P_WIDTH(16), .ACC_WIDTH(16), .N_TERMS(NT)) dut16 (
    .clk(clk), .n_rst(n_rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .out_valid(vld1), .out_ready(out_ready), .out_data(od1), .sat(sat1)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: running sum of accepted beats per instance, index 0 = 24-bit, 1 = 16-bit.
  int     m_w[2] = '{24, 16};
  longint m_acc[2];
  int     m_cnt[2];
  bit     m_hold[2];
  bit     m_sat[2];

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    m = longint'(1) << w;
    v = v % m;
    if (v >= m / 2) v -= m;
    if (v < -(m / 2)) v += m;
    return v;
  endfunction

  task automatic model_clear(input int i);
    m_acc[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_sat[i] = 0;
  endtask

  always @(posedge clk or negedge n_rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!n_rst || clr) model_clear(i);
      else if (m_hold[i]) begin
        if (out_ready) model_clear(i);
      end else if (in_valid) begin
        longint s;
        longint lim;
        s = m_acc[i] + longint'(in_data);
        lim = longint'(1) << (m_w[i] - 1);
`ifdef MAC_ACC_SAT_EN
        if (s > lim - 1) begin s = lim - 1; m_sat[i] = 1; end
        else if (s < -lim) begin s = -lim; m_sat[i] = 1; end
`else
        s = wrapw(s, m_w[i]);
`endif
        m_acc[i] = s;
        m_cnt[i]++;
        if (m_cnt[i] == NT) m_hold[i] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      chk("in_ready24",  longint'(rdy0), longint'(!m_hold[0]));
      chk("out_valid24", longint'(vld0), longint'(m_hold[0]));
      chk("in_ready16",  longint'(rdy1), longint'(!m_hold[1]));
      chk("out_valid16", longint'(vld1), longint'(m_hold[1]));
      if (m_hold[0]) begin
        chk("out_data24", longint'(od0), m_acc[0]);
        chk("sat24",      longint'(sat0), longint'(m_sat[0]));
      end
      if (m_hold[1]) begin
        chk("out_data16", longint'(od1), m_acc[1]);
        chk("sat16",      longint'(sat1), longint'(m_sat[1]));
      end
    end
  end

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_data = 16'h5A5A;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", longint'(vld0), 0);
    chk("rst_out_data",  longint'({od0}), 0);
    chk("rst_sat",       longint'(sat0), 0);
    n_rst = 1'b1;
    #1 chk("rst_in_ready", longint'(rdy0), 1);

    // 1,2,3,4 back to back
    send(1); send(2); send(3); send(4);
    chk("seq1234_valid", longint'(vld0), 1);
    chk("seq1234_data",  longint'(od0), 10);
    chk("seq1234_sat",   longint'(sat0), 0);
    drain();

    // four beats of -256
    for (int k = 0; k < 4; k++) send(-256);
    chk("neg256_data", longint'({od0[23:0]} & 24'hFFFFFF), longint'(24'hFFFC00));

    // held result while upstream keeps offering beats
    in_valid = 1'b1; in_data = 16'sd7;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", longint'(rdy0), 0);
      chk("hold_data",     longint'(od0), -1024);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release_idle", longint'(vld0), 0);
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("after_hold_sum", longint'(od0), 28);
    drain();

    // overflow of the 16-bit instance
    for (int k = 0; k < 4; k++) send(16'h7FFF);
    chk("big24_data", longint'(od0), 131068);
`ifdef MAC_ACC_SAT_EN
    chk("ovf16_data", longint'({od1} & 16'hFFFF), longint'(16'h7FFF));
    chk("ovf16_sat",  longint'(sat1), 1);
`else
    chk("ovf16_data", longint'({od1} & 16'hFFFF), longint'(16'hFFFC));
    chk("ovf16_sat",  longint'(sat1), 0);
`endif
    drain();

    // abort after two beats, clr wins over a same-cycle beat
    send(9); send(9);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'sd9;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_no_valid", longint'(vld0), 0);
    send(5); send(5); send(5); send(5);
    chk("after_clr_data", longint'(od0), 20);
    drain();

    // gaps between beats with junk on in_data
    send(1); idle_cycle(); send(-3); idle_cycle(); idle_cycle(); send(100); idle_cycle(); send(-50);
    chk("gapped_data", longint'(od0), 48);
    drain();

    // asynchronous reset while holding
    for (int k = 0; k < 4; k++) send(3);
    chk("pre_rst_valid", longint'(vld0), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_valid24", longint'(vld0), 0);
    chk("async_rst_valid16", longint'(vld1), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    #1 chk("post_rst_ready", longint'(rdy0), 1);
    for (int k = 0; k < 4; k++) send(1);
    chk("post_rst_data", longint'(od0), 4);
    drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
